// File: rtl/serlink_pkg.sv
// Shared state encodings, line level and frame sizing for the serial link.
// SERLINK_PARITY_EN adds one even-parity bit per frame.
package serlink_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

`ifdef SERLINK_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int width, input int nwords);
        return 2 + width * nwords + PARITY_BITS;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serlink_nw_if.sv
// Parallel-side and line-side signals of the serial link, grouped for the top port.
// master = host/line driver, slave = link.
interface serlink_nw_if #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
);
    localparam int BW = serlink_pkg::clog2_min1(WIDTH);
    localparam int WW = serlink_pkg::clog2_min1(NWORDS);

    logic [NWORDS-1:0]       ld;
    logic [NWORDS*WIDTH-1:0] wr_data;
    logic                    transmit;
    logic                    tx_data;
    logic                    busy;
    logic                    sent_n;
    logic                    rx_in;
    logic [NWORDS*WIDTH-1:0] rx_words;
    logic [BW-1:0]           qbit;
    logic [WW-1:0]           qwrd;
    logic                    received_n;
    logic                    frame_err;
    logic                    parity_err;

    modport master (
        output ld, wr_data, transmit, rx_in,
        input  tx_data, busy, sent_n, rx_words, qbit, qwrd,
               received_n, frame_err, parity_err
    );

    modport slave (
        input  ld, wr_data, transmit, rx_in,
        output tx_data, busy, sent_n, rx_words, qbit, qwrd,
               received_n, frame_err, parity_err
    );

endinterface

// File: rtl/serlink_rx.sv
// Serial receiver: start-bit detect, word/bit counters, frame assembly, stop/parity checks.
// rx_words/received_n update one cycle after the stop-bit sample; no backpressure.
module serlink_rx
    import serlink_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int NWORDS = 4,
    localparam int NB     = WIDTH * NWORDS,
    localparam int BW     = clog2_min1(WIDTH),
    localparam int WW     = clog2_min1(NWORDS)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          rx_in,
    output logic [NB-1:0] rx_words,
    output logic [BW-1:0] qbit,
    output logic [WW-1:0] qwrd,
    output logic          received_n,
    output logic          frame_err,
    output logic          parity_err
);

    state_t        state;
    logic [NB-1:0] asm_q;
`ifdef SERLINK_PARITY_EN
    logic          pacc;
    logic          perr;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_IDLE;
            asm_q      <= '0;
            qbit       <= '0;
            qwrd       <= '0;
            rx_words   <= '0;
            received_n <= 1'b1;
            frame_err  <= 1'b0;
`ifdef SERLINK_PARITY_EN
            pacc       <= 1'b0;
            perr       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            received_n <= 1'b1;
            frame_err  <= 1'b0;
`ifdef SERLINK_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rx_in != LINE_IDLE) begin
                        state <= ST_DATA;
                        qbit  <= '0;
                        qwrd  <= '0;
`ifdef SERLINK_PARITY_EN
                        pacc  <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    // Bits arrive word 0 LSB first, so shifting in at the top
                    // leaves the first bit at position 0 after NB samples.
                    asm_q <= {rx_in, asm_q[NB-1:1]};
`ifdef SERLINK_PARITY_EN
                    pacc  <= pacc ^ rx_in;
`endif
                    if (qbit == BW'(WIDTH - 1)) begin
                        qbit <= '0;
                        if (qwrd == WW'(NWORDS - 1)) begin
                            qwrd <= '0;
`ifdef SERLINK_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            qwrd <= qwrd + WW'(1);
                        end
                    end else begin
                        qbit <= qbit + BW'(1);
                    end
                end
`ifdef SERLINK_PARITY_EN
                ST_PARITY: begin
                    perr  <= pacc ^ rx_in;
                    state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    state <= ST_IDLE;
                    if (rx_in != LINE_IDLE) begin
                        frame_err <= 1'b1;
`ifdef SERLINK_PARITY_EN
                    end else if (perr) begin
                        parity_err <= 1'b1;
`endif
                    end else begin
                        rx_words   <= asm_q;
                        received_n <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SERLINK_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/serlink_nw.sv
// NWORDS x WIDTH holding regs serialised with start/stop framing (SERLINK_PARITY_EN adds parity).
// Frame = 2+NWORDS*WIDTH(+1) cycles; transmit while busy is dropped, not queued.
module serlink_nw
    import serlink_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
) (
    input logic         clk,
    input logic         clr_n,
    serlink_nw_if.slave bus
);

    localparam int NB = WIDTH * NWORDS;
    localparam int CW = $clog2(NB + 1);

    logic [NB-1:0] hold;
    logic [NB-1:0] shreg;
    logic [CW-1:0] cnt;
    state_t        tx_state;
    logic          tx_q;
    logic          busy_q;
    logic          sent_n_q;
`ifdef SERLINK_PARITY_EN
    logic          par;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hold <= '0;
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (bus.ld[i]) hold[i*WIDTH +: WIDTH] <= bus.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Outputs are registered from the next state, so the line bit for a
    // state appears the cycle that state is entered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tx_state <= ST_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            sent_n_q <= 1'b1;
`ifdef SERLINK_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (bus.transmit) begin
                        shreg    <= hold;
                        tx_q     <= ~LINE_IDLE;
                        busy_q   <= 1'b1;
                        tx_state <= ST_START;
`ifdef SERLINK_PARITY_EN
                        par      <= ^hold;
`endif
                    end
                end
                ST_START: begin
                    tx_q     <= shreg[0];
                    shreg    <= {1'b0, shreg[NB-1:1]};
                    cnt      <= CW'(1);
                    tx_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (cnt == CW'(NB)) begin
`ifdef SERLINK_PARITY_EN
                        tx_q     <= par;
                        tx_state <= ST_PARITY;
`else
                        tx_q     <= LINE_IDLE;
                        sent_n_q <= 1'b0;
                        tx_state <= ST_STOP;
`endif
                    end else begin
                        tx_q  <= shreg[0];
                        shreg <= {1'b0, shreg[NB-1:1]};
                        cnt   <= cnt + CW'(1);
                    end
                end
`ifdef SERLINK_PARITY_EN
                ST_PARITY: begin
                    tx_q     <= LINE_IDLE;
                    sent_n_q <= 1'b0;
                    tx_state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    tx_q     <= LINE_IDLE;
                    sent_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    tx_state <= ST_IDLE;
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_data = tx_q;
    assign bus.busy    = busy_q;
    assign bus.sent_n  = sent_n_q;

    serlink_rx #(
        .WIDTH  (WIDTH),
        .NWORDS (NWORDS)
    ) u_rx (
        .clk        (clk),
        .clr_n      (clr_n),
        .rx_in      (bus.rx_in),
        .rx_words   (bus.rx_words),
        .qbit       (bus.qbit),
        .qwrd       (bus.qwrd),
        .received_n (bus.received_n),
        .frame_err  (bus.frame_err),
        .parity_err (bus.parity_err)
    );

endmodule

// File: tb/tb_serlink_nw.sv
// Loopback bench for serlink_nw: directed and random frames checked cycle by cycle
// against a line-bit model built from the holding-register contents.
module tb_serlink_nw;
    import serlink_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int NB = W * N;
    localparam int FL = frame_len(W, N);
    localparam int PB = FL - 2 - NB;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    always #5 clk = ~clk;

    serlink_nw_if #(.WIDTH(W), .NWORDS(N)) bus ();

    serlink_nw #(.WIDTH(W), .NWORDS(N)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    logic lb = 1'b1;
    logic fv = 1'b1;
    assign bus.rx_in = lb ? bus.tx_data : fv;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  hold_m [N];
    logic [NB-1:0] last_good;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] model_frame();
        logic [NB-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = hold_m[i];
        return f;
    endfunction

    task automatic do_load(input logic [N-1:0] mask, input logic [NB-1:0] data);
        bus.ld      = mask;
        bus.wr_data = data;
        step();
        bus.ld = '0;
        for (int i = 0; i < N; i++) if (mask[i]) hold_m[i] = data[i*W +: W];
    endtask

    // k counts edges after the accept edge (k=0); the stop bit sits at k=FL-1
    // and the receiver reports at k=FL. flip_k corrupts the looped line bit
    // present during period k; hook_k raises transmit (and optionally ld) mid-frame.
    task automatic run_frame(input string tag, input int hook_k, input bit hook_ld,
                             input int hook_word, input logic [W-1:0] hook_val,
                             input int flip_k);
        logic [NB-1:0] d;
        logic          exp_line;
        logic          good;
        logic          is_ferr;
        int            qb;
        int            qw;
        d       = model_frame();
        good    = (flip_k < 0);
        is_ferr = (flip_k == FL - 1);
        bus.transmit = 1'b1;
        step();
        bus.transmit = 1'b0;
        for (int k = 0; k <= FL; k++) begin
            if (k > 0) step();
            if (k == 0)                      exp_line = 1'b0;
            else if (k <= NB)                exp_line = d[k-1];
            else if (PB == 1 && k == NB + 1) exp_line = ^d;
            else                             exp_line = 1'b1;
            qb = (k >= 1 && k <= NB) ? (k - 1) % W : 0;
            qw = (k >= 1 && k <= NB) ? (k - 1) / W : 0;
            chk($sformatf("%s tx_data k=%0d", tag, k), 64'(bus.tx_data), 64'(exp_line));
            chk($sformatf("%s busy k=%0d", tag, k), 64'(bus.busy), 64'(k < FL));
            chk($sformatf("%s sent_n k=%0d", tag, k), 64'(bus.sent_n), 64'(k != FL - 1));
            chk($sformatf("%s qbit k=%0d", tag, k), 64'(bus.qbit), 64'(qb));
            chk($sformatf("%s qwrd k=%0d", tag, k), 64'(bus.qwrd), 64'(qw));
            chk($sformatf("%s received_n k=%0d", tag, k), 64'(bus.received_n),
                64'(!(k == FL && good)));
            chk($sformatf("%s frame_err k=%0d", tag, k), 64'(bus.frame_err),
                64'(k == FL && is_ferr));
            chk($sformatf("%s parity_err k=%0d", tag, k), 64'(bus.parity_err),
                64'(k == FL && !good && !is_ferr));
            if (k == FL && good) last_good = d;
            chk($sformatf("%s rx_words k=%0d", tag, k), 64'(bus.rx_words), 64'(last_good));
            if (k == hook_k) begin
                bus.transmit = 1'b1;
                if (hook_ld) begin
                    bus.ld[hook_word]                = 1'b1;
                    bus.wr_data[hook_word*W +: W]    = hook_val;
                    hold_m[hook_word]                = hook_val;
                end
            end else if (k == hook_k + 1) begin
                bus.transmit = 1'b0;
                bus.ld       = '0;
            end
            if (k == flip_k) begin
                fv = ~bus.tx_data;
                lb = 1'b0;
            end else if (k == flip_k + 1) begin
                lb = 1'b1;
            end
        end
    endtask

    initial begin
        logic [N-1:0]  rmask;
        logic [NB-1:0] rdata;
        bus.ld       = '0;
        bus.wr_data  = '0;
        bus.transmit = 1'b0;
        for (int i = 0; i < N; i++) hold_m[i] = '0;
        last_good = '0;

        // Reset state
        #1 clr_n = 1'b0;
        #1;
        chk("rst tx_data", 64'(bus.tx_data), 64'(1));
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst sent_n", 64'(bus.sent_n), 64'(1));
        chk("rst received_n", 64'(bus.received_n), 64'(1));
        chk("rst rx_words", 64'(bus.rx_words), 64'h0000);
        chk("rst qbit", 64'(bus.qbit), 64'(0));
        chk("rst qwrd", 64'(bus.qwrd), 64'(0));
        chk("rst frame_err", 64'(bus.frame_err), 64'(0));
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        step();

        // Basic frame 3,A,5,F
        do_load(4'hF, 16'hF5A3);
        run_frame("basic", -1, 1'b0, 0, '0, -1);
        chk("basic rx_words", 64'(bus.rx_words), 64'hF5A3);

        // Mid-frame transmit ignored, mid-frame load used by next frame
        run_frame("midtx", 5, 1'b1, 1, 4'h0, -1);
        chk("midtx rx_words", 64'(bus.rx_words), 64'hF5A3);
        run_frame("next", -1, 1'b0, 0, '0, -1);
        chk("next rx_words", 64'(bus.rx_words), 64'hF503);

        // Stop bit forced low
        do_load(4'hF, 16'h1234);
        run_frame("ferr", -1, 1'b0, 0, '0, FL - 1);
        chk("ferr rx_words kept", 64'(bus.rx_words), 64'hF503);
        run_frame("after_ferr", -1, 1'b0, 0, '0, -1);
        chk("after_ferr rx_words", 64'(bus.rx_words), 64'h1234);

        // Reset mid-frame
        do_load(4'hF, 16'hF5A3);
        bus.transmit = 1'b1;
        step();
        bus.transmit = 1'b0;
        repeat (9) step();
        #2 clr_n = 1'b0;
        #1;
        chk("midrst tx_data", 64'(bus.tx_data), 64'(1));
        chk("midrst busy", 64'(bus.busy), 64'(0));
        chk("midrst sent_n", 64'(bus.sent_n), 64'(1));
        chk("midrst qbit", 64'(bus.qbit), 64'(0));
        chk("midrst qwrd", 64'(bus.qwrd), 64'(0));
        chk("midrst rx_words", 64'(bus.rx_words), 64'h0000);
        for (int i = 0; i < N; i++) hold_m[i] = '0;
        last_good = '0;
        @(negedge clk);
        clr_n = 1'b1;
        step();
        do_load(4'hF, 16'hF5A3);
        run_frame("resend", -1, 1'b0, 0, '0, -1);
        chk("resend rx_words", 64'(bus.rx_words), 64'hF5A3);

`ifdef SERLINK_PARITY_EN
        // Data bit 5 appears on the line during period k=6
        run_frame("par_ok", -1, 1'b0, 0, '0, -1);
        run_frame("par_flip", -1, 1'b0, 0, '0, 6);
        chk("par_flip rx_words kept", 64'(bus.rx_words), 64'hF5A3);
`endif

        // Random partial loads and frames
        for (int r = 0; r < 6; r++) begin
            rmask = N'($urandom_range(0, (1 << N) - 1));
            rdata = NB'($urandom);
            do_load(rmask, rdata);
            run_frame($sformatf("rand%0d", r), -1, 1'b0, 0, '0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
